alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_seq_decode.sv | 63 ++++++
 rtl/alu_op_sequencer.sv | 102 ++++++++++
 tb/tb_alu_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU op sequencer: ALU op codes, MIPS opcode/funct fields,
// FSM states and the decoded-issue bundle passed from the decoder to the sequencer.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LUI  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_PARK = 4'hF
    } alu_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } seq_state_e;

    typedef struct packed {
        alu_op_e     ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        legal;
    } dec_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-side and response signals of the ALU op sequencer.
// slave = the sequencer itself; master = requester, external ALU and response consumer.
interface alu_op_sequencer_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] RsData;
    logic [31:0] RtData;

    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Immediate;
    logic [31:0] ALUResult;
    logic        Zero;

    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        ZeroOut;
    logic        Illegal;

    modport slave (
        input  InValid, Instr, RsData, RtData, ALUResult, Zero, OutReady,
        output InReady, ALUControl, A, B, Immediate, OutValid, Result, ZeroOut, Illegal
    );

    modport master (
        output InValid, Instr, RsData, RtData, ALUResult, Zero, OutReady,
        input  InReady, ALUControl, A, B, Immediate, OutValid, Result, ZeroOut, Illegal
    );
endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: MIPS instruction + operands -> ALU control, A, B, Immediate and legal flag.
// Latency: none, purely combinational. Backpressure: none, re-evaluated every cycle.
// Shift funct codes decode only with ALU_SEQ_SHIFT_EN defined; otherwise they fall through as illegal.
module alu_seq_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_dat,
    input  logic [31:0] rt_dat,
    output dec_t        dec
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm16         = instr[15:0];
    // Register-number fields are irrelevant: operand values arrive already read.
    assign unused_fields = ^instr[25:16];

`ifdef ALU_SEQ_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = instr[10:6];
`endif

    always_comb begin
        dec      = '0;
        dec.ctrl = ALU_PARK;
        case (opcode)
            OPC_RTYPE: begin
                dec.legal = 1'b1;
                dec.a     = rs_dat;
                dec.b     = rt_dat;
                case (funct)
                    FN_ADD: dec.ctrl = ALU_ADD;
                    FN_SUB: dec.ctrl = ALU_SUB;
                    FN_AND: dec.ctrl = ALU_AND;
                    FN_OR:  dec.ctrl = ALU_OR;
                    FN_XOR: dec.ctrl = ALU_XOR;
`ifdef ALU_SEQ_SHIFT_EN
                    FN_SLL: begin dec.ctrl = ALU_SLL; dec.a = rt_dat; dec.b = {27'd0, shamt}; end
                    FN_SRL: begin dec.ctrl = ALU_SRL; dec.a = rt_dat; dec.b = {27'd0, shamt}; end
                    FN_SRA: begin dec.ctrl = ALU_SRA; dec.a = rt_dat; dec.b = {27'd0, shamt}; end
`endif
                    default: dec.legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin dec.legal = 1'b1; dec.ctrl = ALU_ADD; dec.a = rs_dat; dec.b = sext16(imm16); end
            OPC_ANDI: begin dec.legal = 1'b1; dec.ctrl = ALU_AND; dec.a = rs_dat; dec.b = zext16(imm16); end
            OPC_ORI:  begin dec.legal = 1'b1; dec.ctrl = ALU_OR;  dec.a = rs_dat; dec.b = zext16(imm16); end
            OPC_XORI: begin dec.legal = 1'b1; dec.ctrl = ALU_XOR; dec.a = rs_dat; dec.b = zext16(imm16); end
            OPC_LUI:  begin dec.legal = 1'b1; dec.ctrl = ALU_LUI; dec.a = rs_dat; dec.imm = zext16(imm16); end
            default:  dec.legal = 1'b0;
        endcase
        // Illegal ops leave the ALU parked and zero operands.
        if (!dec.legal) begin
            dec      = '0;
            dec.ctrl = ALU_PARK;
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one MIPS ALU instruction at a time to an external combinational ALU.
// Latency: handshake cycle to OutValid is 3 cycles for legal ops, 2 for illegal ones.
// Backpressure: one op in flight; InReady only in IDLE, response held in RESP until OutReady (ALU_SEQ_SHIFT_EN enables shifts).
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    alu_op_sequencer_if.slave io
);
    seq_state_e  state_q, state_d;
    logic        in_rdy, out_vld, accept;
    logic [31:0] instr_q, rs_q, rt_q;
    dec_t        dec;
    alu_op_e     ctrl_q;
    logic [31:0] a_q, b_q, imm_q, result_q;
    logic        zero_q, illegal_q;

    alu_seq_decode u_decode (
        .instr  (instr_q),
        .rs_dat (rs_q),
        .rt_dat (rt_q),
        .dec    (dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (io.InValid) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_RESP;
            ST_EXEC:   state_d = ST_RESP;
            ST_RESP: begin
                out_vld = 1'b1;
                if (io.OutReady) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    assign accept = in_rdy && io.InValid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else if (accept) begin
            instr_q <= io.Instr;
            rs_q    <= io.RsData;
            rt_q    <= io.RtData;
        end
    end

    // Parking ALUControl after every op guarantees the next issue is a visible change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= ALU_PARK;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            if (dec.legal) begin
                ctrl_q <= dec.ctrl;
                a_q    <= dec.a;
                b_q    <= dec.b;
                imm_q  <= dec.imm;
            end else begin
                result_q  <= '0;
                zero_q    <= 1'b0;
                illegal_q <= 1'b1;
            end
        end else if (state_q == ST_EXEC) begin
            ctrl_q    <= ALU_PARK;
            result_q  <= io.ALUResult;
            zero_q    <= io.Zero;
            illegal_q <= 1'b0;
        end
    end

    assign io.InReady    = in_rdy;
    assign io.OutValid   = out_vld;
    assign io.ALUControl = ctrl_q;
    assign io.A          = a_q;
    assign io.B          = b_q;
    assign io.Immediate  = imm_q;
    assign io.Result     = result_q;
    assign io.ZeroOut    = zero_q;
    assign io.Illegal    = illegal_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: an instruction-level model predicts every response and
// the EXEC-cycle ALU drive; a negedge monitor compares the DUT against it every cycle.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if bus();

    alu_op_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    always #5 clk = ~clk;

`ifdef ALU_SEQ_SHIFT_EN
    localparam bit          SHIFT_EN = 1'b1;
    localparam logic [31:0] S4_RES   = 32'hF8000000;
    localparam logic [31:0] S4_ILL   = 32'd0;
    localparam logic [31:0] S4_LAT   = 32'd3;
`else
    localparam bit          SHIFT_EN = 1'b0;
    localparam logic [31:0] S4_RES   = 32'd0;
    localparam logic [31:0] S4_ILL   = 32'd1;
    localparam logic [31:0] S4_LAT   = 32'd2;
`endif

    // Environment: a plain combinational ALU behind the sequencer.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = 32'd0;
        case (bus.ALUControl)
            4'd0:    alu_res = bus.A + bus.B;
            4'd1:    alu_res = bus.A - bus.B;
            4'd2:    alu_res = bus.A & bus.B;
            4'd3:    alu_res = bus.A | bus.B;
            4'd4:    alu_res = bus.A ^ bus.B;
            4'd5:    alu_res = {bus.Immediate[15:0], 16'h0000};
            4'd6:    alu_res = bus.A << bus.B[4:0];
            4'd7:    alu_res = bus.A >> bus.B[4:0];
            4'd8:    alu_res = $signed(bus.A) >>> bus.B[4:0];
            default: alu_res = 32'd0;
        endcase
    end
    assign bus.ALUResult = alu_res;
    assign bus.Zero      = (alu_res == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level expectation: what the op means, not how the RTL decodes it.
    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] res;
        logic        chk_b;
        logic        chk_imm;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        m;
        logic [4:0]  sh;
        logic [31:0] se, ze;
        sh = ins[10:6];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        m = '0;
        m.legal = 1'b1;
        m.a = rs;
        m.b = rt;
        m.chk_b = 1'b1;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: begin m.op = 4'd0; m.res = rs + rt; end
                6'h22: begin m.op = 4'd1; m.res = rs - rt; end
                6'h24: begin m.op = 4'd2; m.res = rs & rt; end
                6'h25: begin m.op = 4'd3; m.res = rs | rt; end
                6'h26: begin m.op = 4'd4; m.res = rs ^ rt; end
                6'h00: begin m.op = 4'd6; m.a = rt; m.b = {27'd0, sh}; m.res = rt << sh; m.legal = SHIFT_EN; end
                6'h02: begin m.op = 4'd7; m.a = rt; m.b = {27'd0, sh}; m.res = rt >> sh; m.legal = SHIFT_EN; end
                6'h03: begin m.op = 4'd8; m.a = rt; m.b = {27'd0, sh}; m.res = $signed(rt) >>> sh; m.legal = SHIFT_EN; end
                default: m.legal = 1'b0;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin m.op = 4'd0; m.b = se; m.res = rs + se; end
                6'h0C: begin m.op = 4'd2; m.b = ze; m.res = rs & ze; end
                6'h0D: begin m.op = 4'd3; m.b = ze; m.res = rs | ze; end
                6'h0E: begin m.op = 4'd4; m.b = ze; m.res = rs ^ ze; end
                6'h0F: begin m.op = 4'd5; m.imm = ze; m.chk_b = 1'b0; m.chk_imm = 1'b1; m.res = {ins[15:0], 16'h0000}; end
                default: m.legal = 1'b0;
            endcase
        end
        if (!m.legal) m.res = 32'd0;
        return m;
    endfunction

    // Per-cycle monitor: age counts edges since the handshake cycle.
    bit   pend = 1'b0;
    int   age  = 0;
    exp_t cur  = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend = 1'b0;
                chk("rst_OutValid",   bus.OutValid,   32'd0);
                chk("rst_InReady",    bus.InReady,    32'd1);
                chk("rst_ALUControl", bus.ALUControl, 32'hF);
                chk("rst_A",          bus.A,          32'd0);
                chk("rst_B",          bus.B,          32'd0);
                chk("rst_Immediate",  bus.Immediate,  32'd0);
                chk("rst_Result",     bus.Result,     32'd0);
                chk("rst_ZeroOut",    bus.ZeroOut,    32'd0);
                chk("rst_Illegal",    bus.Illegal,    32'd0);
            end else begin
                if (pend) age++;
                chk("mon_OutValid", bus.OutValid, (pend && age >= (cur.legal ? 3 : 2)) ? 32'd1 : 32'd0);
                chk("mon_InReady",  bus.InReady,  pend ? 32'd0 : 32'd1);
                if (pend && cur.legal && age == 2) begin
                    chk("mon_ALUControl_exec", bus.ALUControl, cur.op);
                    chk("mon_A", bus.A, cur.a);
                    if (cur.chk_b)   chk("mon_B", bus.B, cur.b);
                    if (cur.chk_imm) chk("mon_Immediate", bus.Immediate, cur.imm);
                end else begin
                    chk("mon_ALUControl_park", bus.ALUControl, 32'hF);
                end
                if (pend && age >= (cur.legal ? 3 : 2)) begin
                    chk("mon_Result",  bus.Result,  cur.res);
                    chk("mon_ZeroOut", bus.ZeroOut, (cur.legal && cur.res == 32'd0) ? 32'd1 : 32'd0);
                    chk("mon_Illegal", bus.Illegal, cur.legal ? 32'd0 : 32'd1);
                    if (bus.OutReady) pend = 1'b0;
                end else if (!pend && bus.InValid && bus.InReady) begin
                    pend = 1'b1;
                    age  = 0;
                    cur  = model(bus.Instr, bus.RsData, bus.RtData);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
    task automatic do_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input int hold, input bit junk,
                         output logic [31:0] res, output logic zf, output logic il, output int lat);
        int n;
        bus.InValid = 1'b1;
        bus.Instr   = ins;
        bus.RsData  = rs;
        bus.RtData  = rt;
        n = 0;
        while (!bus.InReady && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        bus.Instr   = $urandom;
        bus.RsData  = $urandom;
        bus.RtData  = $urandom;
        lat = 1;
        while (!bus.OutValid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("op_OutValid_seen", bus.OutValid, 32'd1);
        res = bus.Result;
        zf  = bus.ZeroOut;
        il  = bus.Illegal;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus.InValid = 1'b1;
                bus.Instr   = 32'h00221820;
            end
            @(posedge clk); #1;
            chk("hold_InReady",  bus.InReady,  32'd0);
            chk("hold_OutValid", bus.OutValid, 32'd1);
            chk("hold_Result",   bus.Result,   res);
            chk("hold_Illegal",  bus.Illegal,  il);
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge clk); #1;
        bus.OutReady = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
    } vec_t;

    vec_t vecs [10] = '{
        '{32'h00221824, 32'hF0F0_1234, 32'h0FF0_FF00},  // and
        '{32'h00221825, 32'hF000_0001, 32'h0000_0F00},  // or
        '{32'h00221826, 32'hAAAA_5555, 32'hFFFF_0000},  // xor
        '{32'h3022F0F0, 32'hFFFF_FFFF, 32'h0},          // andi, zero-extended
        '{32'h3422800F, 32'h1234_0000, 32'h0},          // ori, imm bit15 set
        '{32'h3822FFFF, 32'h0000_FFFF, 32'h0},          // xori -> zero
        '{32'h00221820, 32'hFFFF_FFFF, 32'h1},          // add wraps to zero
        '{32'h28220005, 32'h1,         32'h2},          // slti: unsupported
        '{32'h00021800, 32'h3,         32'hDEAD_BEEF},  // sll shamt 0
        '{32'h00021FC2, 32'h3,         32'h8000_0000}   // srl shamt 31
    };

    initial begin
        logic [31:0] r;
        logic        z, il;
        int          lat;
        bus.InValid  = 1'b0;
        bus.Instr    = '0;
        bus.RsData   = '0;
        bus.RtData   = '0;
        bus.OutReady = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_InReady", bus.InReady, 32'd1);

        // addi 5 + (-3)
        do_op(32'h2022FFFD, 32'd5, 32'd0, 0, 1'b0, r, z, il, lat);
        chk("s1_Result", r, 32'd2);
        chk("s1_ZeroOut", z, 32'd0);
        chk("s1_latency", lat, 32'd3);

        // sub equal then differing operands
        do_op(32'h00221822, 32'h1234, 32'h1234, 1, 1'b0, r, z, il, lat);
        chk("s2a_Result", r, 32'd0);
        chk("s2a_ZeroOut", z, 32'd1);
        do_op(32'h00221822, 32'h1234, 32'h1233, 0, 1'b0, r, z, il, lat);
        chk("s2b_Result", r, 32'd1);
        chk("s2b_ZeroOut", z, 32'd0);

        // back-to-back lui with same rs
        do_op(32'h3C0100AB, 32'h77, 32'h0, 0, 1'b0, r, z, il, lat);
        chk("s3a_Result", r, 32'h00AB0000);
        chk("s3_park_between", bus.ALUControl, 32'hF);
        do_op(32'h3C0100CD, 32'h77, 32'h0, 0, 1'b0, r, z, il, lat);
        chk("s3b_Result", r, 32'h00CD0000);

        // sra by 4
        do_op(32'h00021903, 32'h0, 32'h80000000, 0, 1'b0, r, z, il, lat);
        chk("s4_Result", r, S4_RES);
        chk("s4_Illegal", il, S4_ILL);
        chk("s4_latency", lat, S4_LAT);

        // unsupported opcode, consumer stalls 5 cycles while a new request is offered
        do_op(32'hFC000000, 32'h11, 32'h22, 5, 1'b1, r, z, il, lat);
        chk("s5_Illegal", il, 32'd1);
        chk("s5_Result", r, 32'd0);
        chk("s5_ZeroOut", z, 32'd0);
        chk("s5_latency", lat, 32'd2);
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) do_op(vecs[i].ins, vecs[i].rs, vecs[i].rt, i % 3, 1'b0, r, z, il, lat);

        // reset pulse while the op sits in EXEC
        bus.InValid = 1'b1;
        bus.Instr   = 32'h00221820;
        bus.RsData  = 32'd7;
        bus.RtData  = 32'd9;
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("s6_InReady", bus.InReady, 32'd1);
        chk("s6_ALUControl", bus.ALUControl, 32'hF);
        repeat (4) @(posedge clk);
        #1;
        chk("s6_no_OutValid", bus.OutValid, 32'd0);
        do_op(32'h00221820, 32'd2, 32'd3, 0, 1'b0, r, z, il, lat);
        chk("s6_Result", r, 32'd5);
        chk("s6_Illegal", il, 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
